tx_driver: RTL and testbench
============================

TX_DRIVER -- requirements
Module: tx_driver

Interface
REQ-001 SHALL have parameter N, default 16, the number of message bytes in the ROM (N >= 2).
REQ-002 SHALL have port Enable, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port TxEmpty, input, 1 bit: UART transmitter holding register empty, ready for a byte.
REQ-005 SHALL have port XMitGo, output, 1 bit: transmit request; the byte on TxData is to be loaded by the transmitter.
REQ-006 SHALL have port TxData, output, 8 bits: current message byte.
REQ-007 SHALL use port order Enable, Reset, TxEmpty, XMitGo, TxData for positional instantiation.

Function
REQ-008 SHALL hold an internal read-only array named exactly mem, N entries x 8 bits, index 0..N-1, with no write port.
REQ-009 SHALL leave mem contents to be loaded at time zero by hierarchical $readmemh (hex, one byte per line) and SHALL never modify them.
REQ-010 SHALL keep an address register addr of width $clog2(N), and SHALL drive TxData = mem[addr] combinationally at all times.
REQ-011 SHALL implement a Moore FSM with states IDLE, SEND and WAIT, where XMitGo = 1 only in SEND.
REQ-012 IDLE: SHALL move to SEND on a clock edge with TxEmpty = 1, else stay in IDLE.
REQ-013 SEND: SHALL hold XMitGo = 1 until an edge samples TxEmpty = 0 (transmitter accepted the byte), then move to WAIT.
REQ-014 WAIT: SHALL stay in WAIT while TxEmpty = 0; on an edge sampling TxEmpty = 1 it SHALL increment addr and move to SEND.
REQ-015 Address wrap: SHALL set addr N-1 + 1 to 0, so the message repeats endlessly.
REQ-016 SHALL change addr only on the WAIT->SEND transition, so TxData is stable for the whole time XMitGo = 1.
REQ-017 Throughput: with TxEmpty = !XMitGo (zero-latency transmitter), SHALL send one byte per 2 clocks.
REQ-018 Each byte SHALL be requested exactly once; a TxEmpty low pulse outside SEND/WAIT SHALL have no effect.
REQ-019 TxEmpty stuck at 1 in SEND SHALL keep XMitGo high with addr unchanged (no skip).
REQ-020 TxEmpty stuck at 0 in WAIT SHALL stall indefinitely with XMitGo = 0.

Reset
REQ-021 While Reset = 1, SHALL force state IDLE, addr 0 and XMitGo 0 immediately (asynchronous), so TxData = mem[0].
REQ-022 Reset asserted mid-SEND or mid-WAIT SHALL abort the byte; after release the message restarts at mem[0].
REQ-023 After Reset falls, the first SEND SHALL occur at the first edge sampling TxEmpty = 1.

Structure
REQ-024 SHALL place the state enum (IDLE, SEND, WAIT) in a shared package tx_driver_pkg.
REQ-025 SHALL be a single module with no sub-module; the ROM is the inline array mem.

Verification
REQ-026 Load mem = "Hello..." with N = 50, TxEmpty = !XMitGo and a 20 ns clock, then release Reset -> XMitGo pulses every 40 ns, and TxData while XMitGo = 1 reads 'H','e','l','l','o',... in order.
REQ-027 Same setup, run 150 bytes -> after byte index 49 the next TxData is mem[0]; the sequence repeats 3 times exactly.
REQ-028 Transmitter model holding TxEmpty = 0 for 10 clocks after each load -> XMitGo = 0 during the stall, with no duplicate or skipped bytes.
REQ-029 TxEmpty held 1 in SEND for 5 clocks -> XMitGo stays 1 and TxData stays constant for all 5 clocks.
REQ-030 Assert Reset while addr = 7 -> XMitGo = 0 and TxData = mem[0] within the same time step; after release the first byte sent is mem[0].

Source files
------------

// File: rtl/tx_driver_pkg.sv
// ---------------------------------------------------------------------------
// tx_driver_pkg
//
// Purpose:
//   Shared definitions for the message-ROM transmit driver. It holds the FSM
//   state type so that the RTL and any surrounding logic refer to the same
//   encoding by name.
//
// Contents:
//   tx_state_e  - driver FSM states (IDLE, SEND, WAIT)
//   BYTE_W      - width of one message byte / TxData
// ---------------------------------------------------------------------------
package tx_driver_pkg;

  localparam int BYTE_W = 8;

  // IDLE : after reset, waiting for the transmitter to report it is empty
  // SEND : XMitGo asserted, current byte offered to the transmitter
  // WAIT : byte accepted, waiting for the transmitter to drain it
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } tx_state_e;

endpackage : tx_driver_pkg

// File: rtl/tx_driver.sv
// ---------------------------------------------------------------------------
// tx_driver
//
// Purpose:
//   Streams a fixed message, held in an internal read-only byte array, to a
//   UART transmitter. Each byte is offered with XMitGo until the transmitter
//   takes it, then the driver waits for the transmitter to drain before
//   stepping to the next byte. The message wraps and repeats endlessly.
//
// Parameters:
//   N        - number of message bytes in mem (must be at least 2)
//
// Ports:
//   Enable   - in,  system clock; all state updates on its rising edge
//   Reset    - in,  asynchronous active-high reset
//   TxEmpty  - in,  transmitter holding register empty (ready for a byte)
//   XMitGo   - out, transmit request; the transmitter loads TxData
//   TxData   - out, current message byte, always mem[addr_q]
//
// The contents of mem are never written by this module; they are loaded at
// time zero from outside through a hierarchical reference to mem.
// ---------------------------------------------------------------------------
module tx_driver
  import tx_driver_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              Enable,
  input  logic              Reset,
  input  logic              TxEmpty,
  output logic              XMitGo,
  output logic [BYTE_W-1:0] TxData
);

  // Address width; N >= 2 so $clog2 never collapses to zero bits.
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  // Message ROM: no write port, contents supplied at time zero.
  logic [BYTE_W-1:0] mem [0:N-1];

  tx_state_e       state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;

  // State register. Reset is asynchronous so that an abort in the middle
  // of SEND or WAIT drops XMitGo and returns TxData to mem[0] at once.
  always_ff @(posedge Enable or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic. The address only advances on WAIT->SEND, so TxData
  // cannot change while XMitGo is high, and every byte is offered exactly
  // once. The increment wraps at the last byte to replay the message.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (TxEmpty) state_d = SEND;
      end
      SEND: begin
        if (!TxEmpty) state_d = WAIT;
      end
      WAIT: begin
        if (TxEmpty) begin
          state_d = SEND;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Moore output: the request is purely a function of the state.
  always_comb begin
    XMitGo = (state_q == SEND);
  end

  assign TxData = mem[addr_q];

endmodule : tx_driver

// File: tb/tb_tx_driver.sv
// ---------------------------------------------------------------------------
// tb_tx_driver
//
// Drives tx_driver (N = 50) with a behavioural UART transmitter whose
// acceptance delay and drain time are randomised per byte. The expected
// byte stream is simply rom[k % N] for the k-th byte accepted since reset,
// and the spacing between requests follows from the transmitter's drain
// time. Reset is also applied in the middle of SEND and of WAIT.
// ---------------------------------------------------------------------------
module tb_tx_driver;

  localparam int N = 50;

  logic       Enable = 1'b0;
  logic       Reset;
  logic       TxEmpty;
  logic       XMitGo;
  logic [7:0] TxData;

  logic [7:0] rom [0:N-1];
  int assertCount = 0;
  int failCount   = 0;
  int expIdx      = 0;

  tx_driver #(.N(N)) dut (
    .Enable  (Enable),
    .Reset   (Reset),
    .TxEmpty (TxEmpty),
    .XMitGo  (XMitGo),
    .TxData  (TxData)
  );

  // 20 ns clock
  always #10 Enable = ~Enable;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pulse reset, release it on a falling edge, keep the transmitter busy for
  // a few idle clocks (the driver must not start), then report empty and
  // expect the first request for mem[0] on the next edge.
  task automatic applyStimulus(input int idleCycles);
    Reset   = 1'b1;
    TxEmpty = 1'b0;
    @(negedge Enable);
    Reset  = 1'b0;
    expIdx = 0;
    repeat (idleCycles) begin
      @(negedge Enable);
      checkOutput("idleXMitGo", 32'(XMitGo), 32'd0);
      checkOutput("idleTxData", 32'(TxData), 32'(rom[0]));
    end
    TxEmpty = 1'b1;
    @(negedge Enable);
    checkOutput("firstXMitGo", 32'(XMitGo), 32'd1);
    checkOutput("firstTxData", 32'(TxData), 32'(rom[0]));
  endtask

  // Behavioural transmitter. On each falling edge it either drains a byte
  // (TxEmpty low, request must stay off), holds off acceptance of an offered
  // byte (TxEmpty high, request and data must stay put), accepts a byte, or
  // reports empty. After accepting with a drain of e extra clocks the next
  // request must appear exactly e+2 clocks later.
  task automatic runTx(input int nBytes, input int ackMin, input int ackMax,
                       input int stallMin, input int stallMax);
    int sent      = 0;
    int cycles    = 0;
    int stallLeft = 0;
    int ackLeft   = 0;
    int sinceLoad = -1;
    int expGap    = 0;
    bit holding   = 1'b0;
    bit loadNow;
    logic [7:0] holdData = '0;
    while (sent < nBytes && cycles < nBytes * 40 + 50) begin
      @(negedge Enable);
      cycles++;
      loadNow = 1'b0;
      if (sinceLoad >= 0) sinceLoad++;
      if (stallLeft > 0) begin
        checkOutput("stallXMitGo", 32'(XMitGo), 32'd0);
        stallLeft--;
      end else if (holding) begin
        checkOutput("holdXMitGo", 32'(XMitGo), 32'd1);
        checkOutput("holdTxData", 32'(TxData), 32'(holdData));
        ackLeft--;
        if (ackLeft == 0) loadNow = 1'b1;
      end else if (XMitGo) begin
        checkOutput("byteTxData", 32'(TxData), 32'(rom[expIdx % N]));
        if (sinceLoad >= 0) checkOutput("byteGap", sinceLoad, expGap);
        holdData = TxData;
        ackLeft  = int'($urandom_range(ackMax, ackMin));
        if (ackLeft == 0) loadNow = 1'b1;
        else              holding = 1'b1;
      end else begin
        TxEmpty = 1'b1;
      end
      if (loadNow) begin
        holding   = 1'b0;
        expIdx++;
        sent++;
        TxEmpty   = 1'b0;
        stallLeft = int'($urandom_range(stallMax, stallMin));
        sinceLoad = 0;
        expGap    = stallLeft + 2;
      end
    end
    checkOutput("txByteCount", sent, nBytes);
  endtask

  initial begin
    string hello;
    bit found;
    hello = "Hello";
    for (int i = 0; i < N; i++) begin
      rom[i] = (i < 5) ? hello[i] : 8'(97 + (i % 26));
      dut.mem[i] = rom[i];
    end
    Reset   = 1'b0;
    TxEmpty = 1'b0;
    #1 Reset = 1'b1;
    #4;
    checkOutput("rstXMitGo", 32'(XMitGo), 32'd0);
    checkOutput("rstTxData", 32'(TxData), 32'(rom[0]));

    // Zero-latency transmitter, three full passes of the message
    applyStimulus(3 + int'($urandom_range(3, 0)));
    runTx(150, 0, 0, 0, 0);

    // Transmitter that keeps TxEmpty low for 10 clocks after each load
    applyStimulus(2);
    runTx(4, 0, 0, 9, 9);

    // Transmitter slow to accept: TxEmpty stays high in SEND for 5 clocks
    runTx(3, 5, 5, 0, 0);

    // Fully random acceptance and drain times, crossing the wrap point
    runTx(60, 0, 5, 0, 10);

    // Reset while byte 7 is being offered
    applyStimulus(1);
    runTx(7, 0, 0, 0, 0);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge Enable);
      if (XMitGo) found = 1'b1;
      else        TxEmpty = 1'b1;
    end
    checkOutput("reachAddr7", 32'(found), 32'd1);
    checkOutput("addr7TxData", 32'(TxData), 32'(rom[7]));
    #3 Reset = 1'b1;
    #1;
    checkOutput("midSendRstXMitGo", 32'(XMitGo), 32'd0);
    checkOutput("midSendRstTxData", 32'(TxData), 32'(rom[0]));
    applyStimulus(2);
    runTx(5, 0, 2, 0, 3);

    // Reset while waiting for the transmitter to drain
    runTx(3, 0, 0, 8, 8);
    @(negedge Enable);
    checkOutput("midWaitXMitGo", 32'(XMitGo), 32'd0);
    #3 Reset = 1'b1;
    #1;
    checkOutput("midWaitRstXMitGo", 32'(XMitGo), 32'd0);
    checkOutput("midWaitRstTxData", 32'(TxData), 32'(rom[0]));
    applyStimulus(1);
    runTx(3, 0, 3, 0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule : tb_tx_driver
